// File: rtl/score_disp_pkg.sv
// rtl/score_disp_pkg.sv - segment patterns, flash FSM encoding and digit-slot constants
package score_disp_pkg;

    // Active-low segment patterns, bit order {dp,g,f,e,d,c,b,a}; dp always off.
    localparam logic [7:0] SEG_0     = 8'hC0;
    localparam logic [7:0] SEG_1     = 8'hF9;
    localparam logic [7:0] SEG_2     = 8'hA4;
    localparam logic [7:0] SEG_3     = 8'hB0;
    localparam logic [7:0] SEG_4     = 8'h99;
    localparam logic [7:0] SEG_5     = 8'h92;
    localparam logic [7:0] SEG_6     = 8'h82;
    localparam logic [7:0] SEG_7     = 8'hF8;
    localparam logic [7:0] SEG_8     = 8'h80;
    localparam logic [7:0] SEG_9     = 8'h90;
    localparam logic [7:0] SEG_DASH  = 8'hBF;
    localparam logic [7:0] SEG_BLANK = 8'hFF;
    localparam logic [7:0] SEG_ERR   = 8'h86;

    // Flash FSM encoding.
    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_FLASH = 1'b1;

    // Digit slots (dig value) and their active-low anode enables; slot 3 is leftmost.
    localparam logic [1:0] DIG_NUM1  = 2'd0;
    localparam logic [1:0] DIG_BLANK = 2'd1;
    localparam logic [1:0] DIG_DASH  = 2'd2;
    localparam logic [1:0] DIG_NUM2  = 2'd3;

    localparam logic [3:0] AN_NUM1  = 4'b1110;
    localparam logic [3:0] AN_BLANK = 4'b1101;
    localparam logic [3:0] AN_DASH  = 4'b1011;
    localparam logic [3:0] AN_NUM2  = 4'b0111;
    localparam logic [3:0] AN_OFF   = 4'b1111;

endpackage

// File: rtl/score_seg_scan_if.sv
// rtl/score_seg_scan_if.sv - score inputs and display outputs of the scanner
//  num1, num2 : scores from the game (asynchronous to the display clock)
//  an, seg    : active-low digit enables and segment pattern
//  flashing   : high during a catch-celebration flash episode
interface score_seg_scan_if;
    logic [3:0] num1;
    logic [3:0] num2;
    logic [3:0] an;
    logic [7:0] seg;
    logic       flashing;

    modport master (output num1, output num2, input an, input seg, input flashing);
    modport slave  (input num1, input num2, output an, output seg, output flashing);
endinterface

// File: rtl/seg7_decode.sv
// rtl/seg7_decode.sv - 4-bit value to active-low 7-segment pattern
//  value : 0..15 in
//  seg   : pattern out; values above 9 show the error glyph
module seg7_decode
    import score_disp_pkg::*;
(
    input  logic [3:0] value,
    output logic [7:0] seg
);

    always_comb begin
        seg = SEG_ERR;
        case (value)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
            default: seg = SEG_ERR;
        endcase
    end

endmodule

// File: rtl/score_seg_scan.sv
// rtl/score_seg_scan.sv - score resynchroniser, 4-digit display scanner and change flasher
//  clk  : board clock
//  rst  : asynchronous, active-low reset
//  bus  : slave side of score_seg_scan_if (num1/num2 in; an/seg/flashing out)
module score_seg_scan
    import score_disp_pkg::*;
#(
    parameter int CLK_HZ       = 50_000_000,
    parameter int SCAN_DIV     = 12_500,
    parameter int BLINK_DIV    = 6_250_000,
    parameter int FLASH_HALVES = 16
) (
    input  logic              clk,
    input  logic              rst,
    score_seg_scan_if.slave   bus
);

    localparam int SCAN_W  = (SCAN_DIV  > 1) ? $clog2(SCAN_DIV)  : 1;
    localparam int BLINK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam int HALF_W  = $clog2(FLASH_HALVES + 1);

    // An odd half-period count would leave the display dark after an episode.
    if ((FLASH_HALVES % 2) != 0 || CLK_HZ <= 0) begin : g_param_check
        $error("score_seg_scan: FLASH_HALVES must be even and CLK_HZ positive");
    end

    logic [7:0]         sync1, sync2, sync2_d;
    logic [3:0]         shown1, shown2;
    logic               stable, change_ev;

    logic [SCAN_W-1:0]  scan_cnt;
    logic [1:0]         dig;

    logic [0:0]         state;
    logic [BLINK_W-1:0] blink_cnt;
    logic [HALF_W-1:0]  half_cnt;
    logic               phase;

    logic [3:0]         dec_val;
    logic [7:0]         dec_seg;
    logic [3:0]         slot_an;
    logic [7:0]         slot_seg;

    // Both scores share one synchroniser so a simultaneous change lands as one event.
    // A value must sit unchanged in stage 2 for two cycles before it is believed,
    // which rejects single-cycle glitches and mid-transition bit skew.
    assign stable    = (sync2 == sync2_d);
    assign change_ev = stable && (sync2 != {shown2, shown1});

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1   <= '0;
            sync2   <= '0;
            sync2_d <= '0;
            shown1  <= '0;
            shown2  <= '0;
        end else begin
            sync1   <= {bus.num2, bus.num1};
            sync2   <= sync1;
            sync2_d <= sync2;
            if (change_ev) begin
                {shown2, shown1} <= sync2;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            scan_cnt <= '0;
            dig      <= DIG_NUM1;
        end else if (scan_cnt == SCAN_W'(SCAN_DIV - 1)) begin
            scan_cnt <= '0;
            dig      <= dig + 2'd1;
        end else begin
            scan_cnt <= scan_cnt + 1'b1;
        end
    end

    // A new change always restarts the episode from a lit half-period.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= ST_IDLE;
            blink_cnt <= '0;
            half_cnt  <= '0;
            phase     <= 1'b0;
        end else if (change_ev) begin
            state     <= ST_FLASH;
            blink_cnt <= '0;
            half_cnt  <= '0;
            phase     <= 1'b0;
        end else if (state == ST_FLASH) begin
            if (blink_cnt == BLINK_W'(BLINK_DIV - 1)) begin
                blink_cnt <= '0;
                phase     <= ~phase;
                half_cnt  <= half_cnt + 1'b1;
                if (half_cnt == HALF_W'(FLASH_HALVES - 1)) begin
                    state <= ST_IDLE;
                end
            end else begin
                blink_cnt <= blink_cnt + 1'b1;
            end
        end
    end

    assign dec_val = (dig == DIG_NUM2) ? shown2 : shown1;

    seg7_decode u_decode (
        .value (dec_val),
        .seg   (dec_seg)
    );

    always_comb begin
        slot_an  = AN_NUM1;
        slot_seg = dec_seg;
        case (dig)
            DIG_NUM1:  begin slot_an = AN_NUM1;  slot_seg = dec_seg;   end
            DIG_BLANK: begin slot_an = AN_BLANK; slot_seg = SEG_BLANK; end
            DIG_DASH:  begin slot_an = AN_DASH;  slot_seg = SEG_DASH;  end
            default:   begin slot_an = AN_NUM2;  slot_seg = dec_seg;   end
        endcase
    end

    // an and seg are registered together so a digit change never shows the
    // previous slot's segments on the new anode.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bus.an       <= AN_OFF;
            bus.seg      <= SEG_BLANK;
            bus.flashing <= 1'b0;
        end else begin
            bus.an       <= phase ? AN_OFF : slot_an;
            bus.seg      <= slot_seg;
            bus.flashing <= (state == ST_FLASH);
        end
    end

endmodule

// File: tb/tb_score_seg_scan.sv
// tb/tb_score_seg_scan.sv - self-checking bench for score_seg_scan
module tb_score_seg_scan;

    localparam int SD = 4;
    localparam int BD = 8;
    localparam int FH = 4;
    localparam int EP = BD * FH;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    score_seg_scan_if bus ();

    score_seg_scan #(
        .CLK_HZ       (100_000_000),
        .SCAN_DIV     (SD),
        .BLINK_DIV    (BD),
        .FLASH_HALVES (FH)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks   = 0;
    int failures = 0;

    // Reference model: hist[k] is the {num2,num1} value sampled by rising edge k
    // after reset release; the shown score follows a value that has been seen
    // on two consecutive edges, two edges after the second of them.
    logic [7:0] hist [0:8191];
    int         e;
    logic [3:0] m1, m2;
    int         last_ev;
    bit         ev_valid;
    logic [3:0] cur1, cur2;
    int         rise_cnt, high_cnt;
    logic       prev_fl;

    function automatic logic [7:0] h(input int k);
        return (k < 1) ? 8'h00 : hist[k];
    endfunction

    function automatic logic [7:0] seg_code(input logic [3:0] v);
        case (v)
            4'd0: return 8'hC0;
            4'd1: return 8'hF9;
            4'd2: return 8'hA4;
            4'd3: return 8'hB0;
            4'd4: return 8'h99;
            4'd5: return 8'h92;
            4'd6: return 8'h82;
            4'd7: return 8'hF8;
            4'd8: return 8'h80;
            4'd9: return 8'h90;
            default: return 8'h86;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            failures++;
            $error("FAIL %s e=%0d observed=%h expected=%h", tag, e, obs, exp_v);
        end
    endtask

    task automatic model_reset();
        e        = 0;
        m1       = 4'd0;
        m2       = 4'd0;
        ev_valid = 1'b0;
        last_ev  = 0;
        prev_fl  = 1'b0;
    endtask

    task automatic cyc(input logic [3:0] a, input logic [3:0] b);
        int         p;
        int         slot;
        bit         fl;
        bit         dark;
        logic [3:0] exp_an;
        logic [7:0] exp_seg;
        logic [7:0] v2, v3;
        bus.num1   = a;
        bus.num2   = b;
        hist[e+1]  = {b, a};
        @(negedge clk);
        e++;
        // Outputs after edge e reflect the display state reached at edge e-1.
        p    = e - 1;
        slot = (p / SD) % 4;
        fl   = ev_valid && ((p - last_ev) < EP);
        dark = fl && ((((p - last_ev) / BD) % 2) == 1);
        case (slot)
            0:       begin exp_an = 4'hE; exp_seg = seg_code(m1); end
            1:       begin exp_an = 4'hD; exp_seg = 8'hFF;        end
            2:       begin exp_an = 4'hB; exp_seg = 8'hBF;        end
            default: begin exp_an = 4'h7; exp_seg = seg_code(m2); end
        endcase
        if (dark) exp_an = 4'hF;
        v2 = h(e - 2);
        v3 = h(e - 3);
        if (v2 == v3 && v2 != {m2, m1}) begin
            {m2, m1} = v2;
            last_ev  = e;
            ev_valid = 1'b1;
        end
        chk("an", {4'h0, bus.an}, {4'h0, exp_an});
        chk("seg", bus.seg, exp_seg);
        chk("flashing", {7'h0, bus.flashing}, {7'h0, fl});
        if (bus.flashing) high_cnt++;
        if (bus.flashing && !prev_fl) rise_cnt++;
        prev_fl = bus.flashing;
    endtask

    task automatic hold(input int n);
        for (int i = 0; i < n; i++) cyc(cur1, cur2);
    endtask

    task automatic clr_mon();
        rise_cnt = 0;
        high_cnt = 0;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_an"}, {4'h0, bus.an}, 8'h0F);
        chk({tag, "_seg"}, bus.seg, 8'hFF);
        chk({tag, "_fl"}, {7'h0, bus.flashing}, 8'h00);
    endtask

    initial begin
        bus.num1 = 4'd0;
        bus.num2 = 4'd0;
        cur1 = 4'd0;
        cur2 = 4'd0;
        model_reset();
        clr_mon();

        // 1. Reset held with toggling inputs, then release and watch the scan.
        for (int i = 0; i < 6; i++) begin
            bus.num1 = 4'($urandom_range(0, 15));
            bus.num2 = 4'($urandom_range(0, 15));
            @(negedge clk);
            chk_reset_outputs("rst_hold");
        end
        rst = 1'b1;
        model_reset();
        hold(20);

        // 2. num1 0->2: one 32-cycle episode.
        clr_mon();
        cur1 = 4'd2;
        hold(40);
        chk("t2_rises", 8'(rise_cnt), 8'd1);
        chk("t2_high", 8'(high_cnt), 8'(EP));

        // 3. Second change 15 cycles after the first extends the episode.
        clr_mon();
        cur2 = 4'd1;
        hold(15);
        cur1 = 4'd3;
        hold(45);
        chk("t3_rises", 8'(rise_cnt), 8'd1);
        chk("t3_high", 8'(high_cnt), 8'(15 + EP));

        // 4. Rollover of both scores together.
        cur2 = 4'd3;
        hold(40);
        clr_mon();
        cur1 = 4'd0;
        cur2 = 4'd0;
        hold(40);
        chk("t4_rises", 8'(rise_cnt), 8'd1);
        chk("t4_high", 8'(high_cnt), 8'(EP));

        // 5. One-cycle glitch is ignored; then an out-of-range score.
        clr_mon();
        cyc(4'd5, cur2);
        hold(10);
        chk("t5_glitch_rises", 8'(rise_cnt), 8'd0);
        cur1 = 4'hC;
        hold(40);

        // 6. Asynchronous reset in the middle of a flash.
        cur1 = 4'd1;
        hold(14);
        #2 rst = 1'b0;
        #1 chk_reset_outputs("t6_async");
        cur1 = 4'd0;
        cur2 = 4'd0;
        bus.num1 = 4'd0;
        bus.num2 = 4'd0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk_reset_outputs("t6_hold");
        end
        rst = 1'b1;
        model_reset();
        hold(20);

        // Random score activity including short glitches.
        for (int i = 0; i < 600; i++) begin
            case ($urandom_range(0, 9))
                0, 1: begin
                    cur1 = 4'($urandom_range(0, 3));
                    cur2 = 4'($urandom_range(0, 3));
                    cyc(cur1, cur2);
                end
                2: cyc(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
                3: begin
                    cur1 = 4'($urandom_range(0, 15));
                    cyc(cur1, cur2);
                end
                default: cyc(cur1, cur2);
            endcase
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
